// File: rtl/cpu_pkg.sv
// Shared CPU constants: register-file geometry and write-back requester indices.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // Requester slots on the register-file write arbiter.
    localparam int WB_ALU    = 0;
    localparam int WB_LOAD   = 1;
    localparam int WB_MULDIV = 2;
    localparam int WB_LINK   = 3;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational one-hot picker: first set request at or after start, wrapping to 0.
module rr_grant #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] start,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // Upper segment [start..NREQ-1] has priority over the wrapped segment [0..start-1].
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[i] && (i >= int'(start))) begin
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
                any    = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[i] && (i < int'(start))) begin
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the register-file write port; registers the winner on the rising edge.
// Define RF_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (index 0 highest).
module rf_write_arbiter
    import cpu_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int CNT_W = 16,
    localparam int IDX_W = idx_width(NREQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [REG_ADDR_W*NREQ-1:0]   req_addr,
    input  logic [REG_DATA_W*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]              req_ready,
    input  logic                         hold,
    output logic [REG_ADDR_W-1:0]        rW,
    output logic [REG_DATA_W-1:0]        W,
    output logic                         WE,
    output logic [IDX_W-1:0]             last_grant,
    output logic [CNT_W-1:0]             wr_count
);

    logic [NREQ-1:0]       gnt;
    logic [IDX_W-1:0]      gidx;
    logic                  gany;
    logic                  vld_p0;
    logic [REG_ADDR_W-1:0] addr_p0;
    logic [REG_DATA_W-1:0] data_p0;
    logic                  nonzero_p0;

`ifdef RF_ARB_FIXED_PRIO_EN
    rr_grant #(.NREQ(NREQ), .IDX_W(IDX_W)) u_grant (
        .req   (req_valid),
        .start ('0),
        .gnt   (gnt),
        .idx   (gidx),
        .any   (gany)
    );
`else
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;

    rr_grant #(.NREQ(NREQ), .IDX_W(IDX_W)) u_grant (
        .req   (req_valid),
        .start (ptr),
        .gnt   (gnt),
        .idx   (gidx),
        .any   (gany)
    );

    assign ptr_nxt = (gidx == IDX_W'(NREQ - 1)) ? '0 : gidx + IDX_W'(1);
`endif

    // Grant is masked while frozen or in reset so nothing is accepted on those edges.
    assign req_ready = gnt & {NREQ{~hold & ~rst}};
    assign vld_p0    = gany & ~hold & ~rst;

    always_comb begin
        addr_p0 = '0;
        data_p0 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                addr_p0 = req_addr[i*REG_ADDR_W +: REG_ADDR_W];
                data_p0 = req_data[i*REG_DATA_W +: REG_DATA_W];
            end
        end
    end

    // A write to register zero is consumed but never enabled or counted.
    assign nonzero_p0 = (addr_p0 != REG_ZERO);

    // Stage p0 -> output register feeding the falling-edge register-file write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rW         <= '0;
            W          <= '0;
            WE         <= 1'b0;
            last_grant <= '0;
            wr_count   <= '0;
`ifndef RF_ARB_FIXED_PRIO_EN
            ptr        <= '0;
`endif
        end else begin
            WE <= 1'b0;
            if (vld_p0) begin
                rW         <= addr_p0;
                W          <= data_p0;
                WE         <= nonzero_p0;
                last_grant <= gidx;
`ifndef RF_ARB_FIXED_PRIO_EN
                ptr        <= ptr_nxt;
`endif
                if (nonzero_p0)
                    wr_count <= wr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a falling-edge register-file model on rW/W/WE.
module tb_rf_write_arbiter;
    import cpu_pkg::*;

    localparam int NREQ  = 4;
    localparam int CNT_W = 4;
    localparam int IDX_W = 2;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NREQ-1:0]            req_valid;
    logic [REG_ADDR_W*NREQ-1:0] req_addr;
    logic [REG_DATA_W*NREQ-1:0] req_data;
    logic [NREQ-1:0]            req_ready;
    logic                       hold;
    logic [REG_ADDR_W-1:0]      rW;
    logic [REG_DATA_W-1:0]      W;
    logic                       WE;
    logic [IDX_W-1:0]           last_grant;
    logic [CNT_W-1:0]           wr_count;

    logic [31:0] rf [32];
    int tests = 0;
    int fails = 0;

    rf_write_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .hold       (hold),
        .rW         (rW),
        .W          (W),
        .WE         (WE),
        .last_grant (last_grant),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    always @(negedge clk) if (WE) rf[rW] <= W;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        req_addr[i*REG_ADDR_W +: REG_ADDR_W] = a;
        req_data[i*REG_DATA_W +: REG_DATA_W] = d;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        hold = 1'b0;
        req_valid = '0;
        req_addr = '0;
        req_data = '0;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset_dut();
        req_valid = 4'b0001;
        set_req(WB_ALU, 5'd7, 32'hA5A5_A5A5);
        step();
        tests++;
        if (WE !== 1'b1) begin fails++; $display("FAIL reset_pre_we got %b want 1", WE); end
        #1 rst = 1'b1;
        #1;
        tests++;
        if (WE !== 1'b0) begin fails++; $display("FAIL reset_async_we got %b want 0", WE); end
        tests++;
        if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        req_valid = '0;
        @(negedge clk); #1;
        tests++;
        if (rf[7] !== 32'h0) begin fails++; $display("FAIL reset_suppressed_write got %h want 0", rf[7]); end
        step();
        rst = 1'b0;
        #1;
        tests++;
        if ({rW, W, WE, last_grant, wr_count} !== '0)
        begin fails++; $display("FAIL reset_outputs rW=%0d W=%h WE=%b lg=%0d cnt=%0d want all 0", rW, W, WE, last_grant, wr_count); end
        req_valid = 4'b1111;
        #1;
        tests++;
        if (req_ready !== 4'b0001) begin fails++; $display("FAIL reset_ptr got %b want 0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_single();
        reset_dut();
        req_valid = 4'b0010;
        set_req(WB_LOAD, 5'd5, 32'hDEAD_BEEF);
        #1;
        tests++;
        if (req_ready !== 4'b0010) begin fails++; $display("FAIL single_ready got %b want 0010", req_ready); end
        step();
        req_valid = '0;
        tests++;
        if (WE !== 1'b1 || rW !== 5'd5 || W !== 32'hDEAD_BEEF)
        begin fails++; $display("FAIL single_out WE=%b rW=%0d W=%h want 1/5/deadbeef", WE, rW, W); end
        tests++;
        if (wr_count !== 4'd1) begin fails++; $display("FAIL single_count got %0d want 1", wr_count); end
        @(negedge clk); #1;
        tests++;
        if (rf[5] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL single_rf got %h want deadbeef", rf[5]); end
        step();
        tests++;
        if (WE !== 1'b0) begin fails++; $display("FAIL single_we_drop got %b want 0", WE); end
    endtask

    task automatic test_round_robin();
        int g;
        reset_dut();
        for (int i = 0; i < NREQ; i++) set_req(i, 5'(i + 1), 32'h1000_0000 + i);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
`ifdef RF_ARB_FIXED_PRIO_EN
            g = 0;
`else
            g = k % NREQ;
`endif
            #1;
            tests++;
            if (req_ready !== 4'(1 << g)) begin fails++; $display("FAIL rr_ready k=%0d got %b want %b", k, req_ready, 4'(1 << g)); end
            step();
            tests++;
            if (last_grant !== 2'(g) || rW !== 5'(g + 1) || W !== 32'h1000_0000 + g)
            begin fails++; $display("FAIL rr_grant k=%0d lg=%0d rW=%0d W=%h want %0d", k, last_grant, rW, W, g); end
        end
        req_valid = '0;
    endtask

    task automatic test_reg_zero();
        reset_dut();
        req_valid = 4'b0100;
        set_req(WB_MULDIV, 5'd0, 32'h1234_5678);
        #1;
        tests++;
        if (req_ready !== 4'b0100) begin fails++; $display("FAIL zero_ready got %b want 0100", req_ready); end
        step();
        req_valid = '0;
        tests++;
        if (WE !== 1'b0 || wr_count !== 4'd0 || last_grant !== 2'd2)
        begin fails++; $display("FAIL zero_out WE=%b cnt=%0d lg=%0d want 0/0/2", WE, wr_count, last_grant); end
        @(negedge clk); #1;
        tests++;
        if (rf[0] !== 32'h0) begin fails++; $display("FAIL zero_rf got %h want 0", rf[0]); end
    endtask

    task automatic test_hold();
        reset_dut();
        set_req(WB_ALU, 5'd10, 32'hAAAA_0000);
        set_req(WB_LINK, 5'd11, 32'hBBBB_0003);
        req_valid = 4'b1001;
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++;
            if (req_ready !== 4'b0000) begin fails++; $display("FAIL hold_ready k=%0d got %b want 0000", k, req_ready); end
            step();
            tests++;
            if (WE !== 1'b0) begin fails++; $display("FAIL hold_we k=%0d got %b want 0", k, WE); end
        end
        hold = 1'b0;
        #1;
        tests++;
        if (req_ready !== 4'b0001) begin fails++; $display("FAIL hold_rel_ready got %b want 0001", req_ready); end
        step();
        req_valid = 4'b1000;
        tests++;
        if (WE !== 1'b1 || last_grant !== 2'd0 || rW !== 5'd10)
        begin fails++; $display("FAIL hold_first WE=%b lg=%0d rW=%0d want 1/0/10", WE, last_grant, rW); end
        #1;
        tests++;
        if (req_ready !== 4'b1000) begin fails++; $display("FAIL hold_second_ready got %b want 1000", req_ready); end
        step();
        req_valid = '0;
        tests++;
        if (WE !== 1'b1 || last_grant !== 2'd3 || rW !== 5'd11)
        begin fails++; $display("FAIL hold_second WE=%b lg=%0d rW=%0d want 1/3/11", WE, last_grant, rW); end
    endtask

    task automatic test_wrap();
        int g;
        reset_dut();
        for (int i = 0; i < NREQ; i++) set_req(i, 5'(20 + i), 32'hC000_0000 + i);
        req_valid = 4'b1111;
        for (int k = 0; k < 17; k++) begin
`ifdef RF_ARB_FIXED_PRIO_EN
            g = 0;
`else
            g = k % NREQ;
`endif
            step();
            tests++;
            if (last_grant !== 2'(g)) begin fails++; $display("FAIL wrap_grant k=%0d got %0d want %0d", k, last_grant, g); end
        end
        req_valid = '0;
        tests++;
        if (wr_count !== 4'd1) begin fails++; $display("FAIL wrap_count got %0d want 1", wr_count); end
    endtask

    initial begin
        rst = 1'b1;
        hold = 1'b0;
        req_valid = '0;
        req_addr = '0;
        req_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_reg_zero();
        test_hold();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
